// File: rtl/bg_frame_writer.sv
// Writes the 4-bit grayscale background frame RAM (address = x + y*H_PIX),
// either from an incoming pixel stream or as a constant-level fill.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for start; no writes
// FILL     | one constant-level write per cycle until the last address
// WAIT_SOF | stream accepted, beats discarded until the first s_sof beat
// LOAD     | each accepted beat written at the running linear address
// DONE     | final write on the bus with done high; returns to IDLE
module bg_frame_writer #(
    parameter int H_PIX  = 400,
    parameter int V_PIX  = 300,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 4
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              start,
    input  logic              fill_mode,
    input  logic [DATA_W-1:0] fill_color,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_sof,
    output logic              s_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    output logic              busy,
    output logic              done,
    output logic              frame_err
);

    localparam int COL_W = $clog2(H_PIX);
    localparam int ROW_W = $clog2(V_PIX);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_PIX * V_PIX - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(H_PIX - 1);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WAIT_SOF,
        LOAD,
        DONE
    } state_t;

    state_t            state;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] fill_lvl;

    logic [COL_W-1:0]  col_nxt;
    logic [ROW_W-1:0]  row_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              beat;

    assign s_ready = (state == WAIT_SOF) || (state == LOAD);
    assign busy    = (state != IDLE);
    assign beat    = s_valid && s_ready;

    // Row/column walk replaces a y*H_PIX multiply; addr tracks row*H_PIX+col.
    always_comb begin
        col_nxt  = col + COL_W'(1);
        row_nxt  = row;
        addr_nxt = addr + ADDR_W'(1);
        if (col == COL_LAST) begin
            col_nxt = '0;
            row_nxt = row + ROW_W'(1);
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            addr      <= '0;
            fill_lvl  <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            done      <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        col  <= '0;
                        row  <= '0;
                        addr <= '0;
                        if (fill_mode) begin
                            fill_lvl <= fill_color;
                            state    <= FILL;
                        end else begin
                            state <= WAIT_SOF;
                        end
                    end
                end
                FILL: begin
                    wr_en   <= 1'b1;
                    wr_addr <= addr;
                    wr_data <= fill_lvl;
                    if (addr == LAST_ADDR) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        col  <= col_nxt;
                        row  <= row_nxt;
                        addr <= addr_nxt;
                    end
                end
                WAIT_SOF: begin
                    if (beat && s_sof) begin
                        wr_en   <= 1'b1;
                        wr_addr <= '0;
                        wr_data <= s_data;
                        col     <= COL_W'(1);
                        row     <= '0;
                        addr    <= ADDR_W'(1);
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (beat) begin
                        wr_en   <= 1'b1;
                        wr_data <= s_data;
                        if (s_sof) begin
                            // Resynchronise to the new frame rather than abort.
                            frame_err <= 1'b1;
                            wr_addr   <= '0;
                            col       <= COL_W'(1);
                            row       <= '0;
                            addr      <= ADDR_W'(1);
                        end else begin
                            wr_addr <= addr;
                            if (addr == LAST_ADDR) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                col  <= col_nxt;
                                row  <= row_nxt;
                                addr <= addr_nxt;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bg_frame_writer.sv
// Directed bench for bg_frame_writer, run on a reduced 40x30 frame so every
// scenario (fill, stream, gaps, mid-frame SOF, reset) completes quickly.
module tb_bg_frame_writer;

    localparam int H_T = 40;
    localparam int V_T = 30;
    localparam int N_T = H_T * V_T;
    localparam int LAST_T = N_T - 1;

    logic        pclk = 1'b0;
    logic        rst;
    logic        start;
    logic        fill_mode;
    logic [3:0]  fill_color;
    logic        s_valid;
    logic [3:0]  s_data;
    logic        s_sof;
    logic        s_ready;
    logic [18:0] wr_addr;
    logic [3:0]  wr_data;
    logic        wr_en;
    logic        busy;
    logic        done;
    logic        frame_err;

    int nvec = 0;
    int nerr = 0;
    int nwr, ndone, exp_a, beats, nferr;
    bit fin;
    logic [3:0] d;

    bg_frame_writer #(.H_PIX(H_T), .V_PIX(V_T), .ADDR_W(19), .DATA_W(4)) dut (
        .pclk(pclk), .rst(rst), .start(start), .fill_mode(fill_mode),
        .fill_color(fill_color), .s_valid(s_valid), .s_data(s_data),
        .s_sof(s_sof), .s_ready(s_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_en(wr_en), .busy(busy), .done(done), .frame_err(frame_err)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Outputs sampled 1 time unit after the rising edge; inputs change there too.
    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; fill_mode = 1'b0; fill_color = 4'h0;
        s_valid = 1'b0; s_data = 4'h0; s_sof = 1'b0;
        step(); step();
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        rst = 1'b0;
        step();
        chk("idle_busy", 32'(busy), 32'd0);

        // Fill with level 7; a start with different settings mid-fill must be ignored.
        start = 1'b1; fill_mode = 1'b1; fill_color = 4'h7;
        step();
        start = 1'b0; fill_color = 4'h0;
        chk("fill_busy", 32'(busy), 32'd1);
        chk("fill_first_no_wr", 32'(wr_en), 32'd0);
        chk("fill_s_ready", 32'(s_ready), 32'd0);
        nwr = 0; ndone = 0; exp_a = 0;
        for (int i = 0; i < N_T + 50; i++) begin
            if (i == 100) begin start = 1'b1; fill_mode = 1'b1; fill_color = 4'h3; end
            if (i == 101) begin start = 1'b0; fill_color = 4'h0; end
            step();
            if (wr_en) begin
                chk("fill_addr", 32'(wr_addr), 32'(exp_a));
                chk("fill_data", 32'(wr_data), 32'h7);
                exp_a++;
                nwr++;
            end
            if (done) begin
                ndone++;
                chk("fill_done_addr", 32'(wr_addr), 32'(LAST_T));
                chk("fill_done_busy", 32'(busy), 32'd1);
                break;
            end
        end
        chk("fill_write_count", 32'(nwr), 32'(N_T));
        chk("fill_done_count", 32'(ndone), 32'd1);
        step();
        chk("fill_busy_drop", 32'(busy), 32'd0);
        chk("fill_post_wr_en", 32'(wr_en), 32'd0);
        chk("fill_post_done", 32'(done), 32'd0);

        // Stream load: three stray beats, then a full frame with data = col[3:0].
        start = 1'b1; fill_mode = 1'b0;
        step();
        start = 1'b0;
        chk("ld_busy", 32'(busy), 32'd1);
        chk("ld_wait_ready", 32'(s_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            s_valid = 1'b1; s_sof = 1'b0; s_data = 4'h5;
            step();
            chk("ld_pre_sof_no_wr", 32'(wr_en), 32'd0);
        end
        ndone = 0;
        for (int p = 0; p < N_T; p++) begin
            d = 4'(p % H_T);
            s_valid = 1'b1; s_sof = (p == 0); s_data = d;
            chk("ld_s_ready", 32'(s_ready), 32'd1);
            step();
            chk("ld_wr_en", 32'(wr_en), 32'd1);
            chk("ld_addr", 32'(wr_addr), 32'(p));
            chk("ld_data", 32'(wr_data), 32'(d));
            chk("ld_frame_err", 32'(frame_err), 32'd0);
            if (p == H_T - 1) chk("ld_row0_last_addr", 32'(wr_addr), 32'(H_T - 1));
            if (p == H_T) begin
                chk("ld_row1_first_addr", 32'(wr_addr), 32'(H_T));
                chk("ld_row1_first_data", 32'(wr_data), 32'd0);
            end
            if (done) ndone++;
        end
        s_valid = 1'b0; s_sof = 1'b0;
        chk("ld_done_last", 32'(done), 32'd1);
        chk("ld_done_count", 32'(ndone), 32'd1);
        chk("ld_last_data", 32'(wr_data), 32'((H_T - 1) % 16));
        step();
        chk("ld_busy_drop", 32'(busy), 32'd0);

        // Gapped load with an extra s_sof on the 1000th beat.
        start = 1'b1; fill_mode = 1'b0;
        step();
        start = 1'b0;
        exp_a = 0; beats = 0; fin = 1'b0; nferr = 0; ndone = 0;
        for (int t = 0; t < 4 * N_T && !fin; t++) begin
            if (t % 5 == 2) begin
                s_valid = 1'b0; s_sof = 1'b0;
                chk("gap_s_ready", 32'(s_ready), 32'd1);
                step();
                chk("gap_no_wr", 32'(wr_en), 32'd0);
            end else begin
                if (beats == 0 || beats == 999) exp_a = 0;
                d = 4'(exp_a) ^ 4'hA;
                s_valid = 1'b1; s_sof = (beats == 0 || beats == 999); s_data = d;
                chk("gap_s_ready", 32'(s_ready), 32'd1);
                step();
                chk("gap_wr_en", 32'(wr_en), 32'd1);
                chk("gap_addr", 32'(wr_addr), 32'(exp_a));
                chk("gap_data", 32'(wr_data), 32'(d));
                chk("gap_frame_err", 32'(frame_err), 32'(beats == 999));
                chk("gap_done", 32'(done), 32'(exp_a == LAST_T));
                if (frame_err) nferr++;
                if (done) ndone++;
                if (exp_a == LAST_T) fin = 1'b1;
                exp_a++;
                beats++;
            end
        end
        s_valid = 1'b0; s_sof = 1'b0;
        chk("sof_finished", 32'(fin), 32'd1);
        chk("sof_beat_count", 32'(beats), 32'(999 + N_T));
        chk("sof_err_count", 32'(nferr), 32'd1);
        chk("sof_done_count", 32'(ndone), 32'd1);
        step();
        chk("sof_busy_drop", 32'(busy), 32'd0);

        // Reset mid-frame at address 500, then restart with a fill.
        start = 1'b1; fill_mode = 1'b0;
        step();
        start = 1'b0;
        for (int p = 0; p <= 500; p++) begin
            s_valid = 1'b1; s_sof = (p == 0); s_data = 4'(p);
            step();
        end
        chk("mid_addr_before_rst", 32'(wr_addr), 32'd500);
        rst = 1'b1;
        step();
        chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_s_ready", 32'(s_ready), 32'd0);
        rst = 1'b0; s_valid = 1'b0; s_sof = 1'b0;
        step();
        chk("mid_idle_wr_en", 32'(wr_en), 32'd0);
        chk("mid_idle_done", 32'(done), 32'd0);
        start = 1'b1; fill_mode = 1'b1; fill_color = 4'h2;
        step();
        start = 1'b0;
        step();
        chk("restart_wr_en", 32'(wr_en), 32'd1);
        chk("restart_addr0", 32'(wr_addr), 32'd0);
        chk("restart_data", 32'(wr_data), 32'h2);
        step();
        chk("restart_addr1", 32'(wr_addr), 32'd1);
        rst = 1'b1;
        step();
        chk("final_rst_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
